// File: rtl/epl_read_ctrl_sub.sv
// Read sequencer for the EPLFFRAM02 array: splits the word address into row/column and times WL, SAE and the read strobe.
// Latency: ack in cycle 0, read strobe in cycle SA_WAIT+2; minimum access period SA_WAIT+3 cycles.
// Backpressure: one access at a time; a request held while busy is acked in the next IDLE cycle, never queued.
module epl_read_ctrl_sub #(
    parameter  int ADDR_WIDTH = 8,
    parameter  int SA_WAIT    = 2,
    localparam int ADDR_AYO   = 2
) (
    input  logic                  pClk_i,
    input  logic                  nRst_i,
    input  logic                  pReq_i,
    input  logic [ADDR_WIDTH-1:0] pAddr_i,
    output logic                  pAck_o,
    output logic                  pBusy_o,
    output logic [ADDR_WIDTH-2:0] pAxr_o,
    output logic                  pWl_o,
    output logic                  pSae_o,
    output logic [ADDR_AYO-1:0]   pAcy2_o,
    output logic                  pRead01_o
);

    if (SA_WAIT < 1 || SA_WAIT > 15) begin : gBadSaWait
        $error("epl_read_ctrl_sub: SA_WAIT=%0d outside legal range 1..15", SA_WAIT);
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WL    = 2'd1,
        SENSE = 2'd2,
        LATCH = 2'd3
    } stateT;

    localparam logic [3:0] SA_CNT_LOAD = 4'(SA_WAIT - 1);

    stateT                 state;
    stateT                 stateNext;
    logic [3:0]            cnt;
    logic [3:0]            cntNext;
    logic                  capture;
    logic [ADDR_WIDTH-2:0] axrNext;
    logic [ADDR_AYO-1:0]   acyNext;
    logic                  wlNext;
    logic                  saeNext;
    logic                  readNext;
    logic                  busyNext;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (pReq_i) begin
                    capture   = 1'b1;
                    stateNext = WL;
                end
            end
            WL: begin
                cntNext   = SA_CNT_LOAD;
                stateNext = SENSE;
            end
            SENSE: begin
                if (cnt == 4'd0) begin
                    stateNext = LATCH;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            LATCH: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Array controls are registered from the next state so every output comes straight off a flop.
        wlNext   = (stateNext != IDLE);
        busyNext = (stateNext != IDLE);
        saeNext  = (stateNext == SENSE) || (stateNext == LATCH);
        readNext = (stateNext == LATCH);

        axrNext = capture ? pAddr_i[ADDR_WIDTH-1:1] : pAxr_o;
        if (capture) begin
            acyNext = pAddr_i[0] ? 2'b10 : 2'b01;
        end else if (stateNext == IDLE) begin
            acyNext = 2'b00;
        end else begin
            acyNext = pAcy2_o;
        end
    end

    // Gated by reset so no ack is issued for a request that cannot be captured.
    assign pAck_o = capture && nRst_i;

    always_ff @(posedge pClk_i) begin
        if (!nRst_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pBusy_o   <= 1'b0;
            pAxr_o    <= '0;
            pWl_o     <= 1'b0;
            pSae_o    <= 1'b0;
            pAcy2_o   <= 2'b00;
            pRead01_o <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            pBusy_o   <= busyNext;
            pAxr_o    <= axrNext;
            pWl_o     <= wlNext;
            pSae_o    <= saeNext;
            pAcy2_o   <= acyNext;
            pRead01_o <= readNext;
        end
    end

endmodule

// File: tb/tb_epl_read_ctrl_sub.sv
// Directed bench for epl_read_ctrl_sub: three instances (SA_WAIT = 2, 1, 15) share stimulus.
// A small behavioural read mux on instance A checks the column data presented after the strobe.
module tb_epl_read_ctrl_sub;

    localparam logic [7:0] COL_EVEN = 8'hA5;
    localparam logic [7:0] COL_ODD  = 8'h3C;

    logic       pClk = 1'b0;
    logic       nRst = 1'b0;
    logic       req  = 1'b0;
    logic [7:0] addr = 8'h00;

    logic       ackA, busyA, wlA, saeA, rdA;
    logic       ackB, busyB, wlB, saeB, rdB;
    logic       ackC, busyC, wlC, saeC, rdC;
    logic [6:0] axrA, axrB, axrC;
    logic [1:0] acyA, acyB, acyC;

    logic       tbRead1 = 1'b0;
    logic [7:0] tbDo    = 8'h00;

    int nChecks = 0;
    int nPass   = 0;

    always #5 pClk = ~pClk;

    epl_read_ctrl_sub #(.ADDR_WIDTH(8), .SA_WAIT(2)) uDutA (
        .pClk_i(pClk), .nRst_i(nRst), .pReq_i(req), .pAddr_i(addr),
        .pAck_o(ackA), .pBusy_o(busyA), .pAxr_o(axrA), .pWl_o(wlA),
        .pSae_o(saeA), .pAcy2_o(acyA), .pRead01_o(rdA));

    epl_read_ctrl_sub #(.ADDR_WIDTH(8), .SA_WAIT(1)) uDutB (
        .pClk_i(pClk), .nRst_i(nRst), .pReq_i(req), .pAddr_i(addr),
        .pAck_o(ackB), .pBusy_o(busyB), .pAxr_o(axrB), .pWl_o(wlB),
        .pSae_o(saeB), .pAcy2_o(acyB), .pRead01_o(rdB));

    epl_read_ctrl_sub #(.ADDR_WIDTH(8), .SA_WAIT(15)) uDutC (
        .pClk_i(pClk), .nRst_i(nRst), .pReq_i(req), .pAddr_i(addr),
        .pAck_o(ackC), .pBusy_o(busyC), .pAxr_o(axrC), .pWl_o(wlC),
        .pSae_o(saeC), .pAcy2_o(acyC), .pRead01_o(rdC));

    // Downstream read mux stand-in: registers the selected column group on the strobe.
    always @(posedge pClk) begin
        tbRead1 <= rdA;
        if (rdA) begin
            tbDo <= (acyA == 2'b10) ? COL_ODD : (acyA == 2'b01) ? COL_EVEN : 8'h00;
        end
    end

    wire [5:0] vecA = {busyA, wlA, saeA, rdA, acyA};
    wire [5:0] vecB = {busyB, wlB, saeB, rdB, acyB};
    wire [5:0] vecC = {busyC, wlC, saeC, rdC, acyC};

    task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end else begin
            nPass++;
        end
    endtask

    // Expected {busy, wl, sae, rd, acy} for cycle c (c >= 1) of an access acked in cycle 0.
    function automatic logic [5:0] expVec(input int c, input int saw, input logic [1:0] acy);
        logic act;
        act = (c >= 1) && (c <= saw + 2);
        return {act, act, act && (c >= 2), (c == saw + 2), act ? acy : 2'b00};
    endfunction

    task automatic stepIn(input logic r, input logic [7:0] a);
        @(negedge pClk);
        req  = r;
        addr = a;
        #1;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 40; i++) begin
            stepIn(1'b0, 8'h00);
            if (!(busyA || busyB || busyC)) break;
        end
        chkVal("idle", {29'd0, busyA, busyB, busyC}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdCycA, rdCycB, rdCycC, saeCntB, saeCntC, strobes;
        int ackCnt, ack1, ack2, rd1, rd2;
        logic [1:0] acyRd1, acyRd2, prevAcy;

        // Reset values
        repeat (3) @(negedge pClk);
        #1;
        chkVal("rstA", {ackA, vecA, axrA}, 32'd0);
        chkVal("rstB", {ackB, vecB, axrB}, 32'd0);
        chkVal("rstC", {ackC, vecC, axrC}, 32'd0);
        @(negedge pClk);
        nRst = 1'b1;
        #1;
        stepIn(1'b0, 8'h00);
        chkVal("relA", {ackA, vecA, axrA}, 32'd0);

        // Single even read, all three SA_WAIT values in parallel
        stepIn(1'b1, 8'h2A);
        chkVal("ack0", {29'd0, ackA, ackB, ackC}, 32'd7);
        chkVal("busy0", {31'd0, busyA}, 32'd0);
        rdCycA = -1; rdCycB = -1; rdCycC = -1; saeCntB = 0; saeCntC = 0;
        for (int c = 1; c <= 18; c++) begin
            stepIn(1'b0, 8'h2A);
            chkVal($sformatf("evA c%0d", c), {26'd0, vecA}, {26'd0, expVec(c, 2, 2'b01)});
            chkVal($sformatf("evB c%0d", c), {26'd0, vecB}, {26'd0, expVec(c, 1, 2'b01)});
            chkVal($sformatf("evC c%0d", c), {26'd0, vecC}, {26'd0, expVec(c, 15, 2'b01)});
            if (c == 1) chkVal("axr even", {25'd0, axrA}, 32'h15);
            if (rdA) rdCycA = c;
            if (rdB) rdCycB = c;
            if (rdC) rdCycC = c;
            if (saeB) saeCntB++;
            if (saeC) saeCntC++;
        end
        chkVal("rdCycA", rdCycA, 4);
        chkVal("rdCycB", rdCycB, 3);
        chkVal("rdCycC", rdCycC, 17);
        chkVal("saeCntB", saeCntB, 2);
        chkVal("saeCntC", saeCntC, 16);
        waitIdle();

        // Odd read through the mux; address changes right after the ack
        stepIn(1'b1, 8'h2B);
        chkVal("ackOdd", {31'd0, ackA}, 32'd1);
        strobes = 0;
        for (int c = 1; c <= 6; c++) begin
            stepIn(1'b0, 8'h00);
            if (c == 1) begin
                chkVal("acy odd", {30'd0, acyA}, 32'd2);
                chkVal("axr odd", {25'd0, axrA}, 32'h15);
            end
            if (c == 5) chkVal("mux c5", {23'd0, tbRead1, tbDo}, {23'd0, 1'b1, COL_ODD});
            if (rdA) strobes++;
        end
        chkVal("strobes odd", strobes, 1);
        waitIdle();

        // Back-to-back with request held
        ackCnt = 0; ack1 = -1; ack2 = -1; rd1 = -1; rd2 = -1;
        acyRd1 = 2'b00; acyRd2 = 2'b00; prevAcy = 2'b00;
        for (int c = 0; c <= 10; c++) begin
            stepIn(c <= 5, (c == 0) ? 8'h00 : 8'h01);
            if (ackA) begin
                ackCnt++;
                if (ack1 < 0) ack1 = c; else ack2 = c;
            end
            if (rdA) begin
                chkVal($sformatf("acy stable c%0d", c), {30'd0, acyA}, {30'd0, prevAcy});
                if (rd1 < 0) begin rd1 = c; acyRd1 = acyA; end
                else begin rd2 = c; acyRd2 = acyA; end
            end
            prevAcy = acyA;
        end
        chkVal("b2b ackCnt", ackCnt, 2);
        chkVal("b2b ack1", ack1, 0);
        chkVal("b2b ack2", ack2, 5);
        chkVal("b2b rd1", rd1, 4);
        chkVal("b2b rd2", rd2, 9);
        chkVal("b2b acy1", {30'd0, acyRd1}, 32'd1);
        chkVal("b2b acy2", {30'd0, acyRd2}, 32'd2);
        waitIdle();

        // Reset in cycle 3 of an access, request held through release
        stepIn(1'b1, 8'h2A);
        chkVal("mid ack0", {31'd0, ackA}, 32'd1);
        stepIn(1'b1, 8'h2A);
        stepIn(1'b1, 8'h2A);
        @(negedge pClk);
        nRst = 1'b0;
        #1;
        chkVal("mid c3 sae", {30'd0, saeA, rdA}, 32'd2);
        @(negedge pClk);
        #1;
        chkVal("mid rstA", {ackA, vecA, axrA}, 32'd0);
        chkVal("mid rstB", {ackB, vecB, axrB}, 32'd0);
        chkVal("mid rstC", {ackC, vecC, axrC}, 32'd0);
        @(negedge pClk);
        nRst = 1'b1;
        #1;
        chkVal("mid reack", {31'd0, ackA}, 32'd1);
        stepIn(1'b0, 8'h00);
        chkVal("mid busy", {30'd0, busyA, ackA}, 32'd2);
        waitIdle();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
